// File: rtl/cmp_sort_pkg.sv
// cmp_sort_pkg: shared definitions for the cmp_sort_ctrl bubble-sort block.
//   state_e      : controller state encoding (load, sort, drain)
//   DefaultN     : default batch size in words
//   DefaultDataW : default word width in bits
//   clog2()      : index width for a given word count (never less than 1)
package cmp_sort_pkg;

  localparam int unsigned DefaultN     = 8;
  localparam int unsigned DefaultDataW = 4;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StSort  = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Bits needed to address 0..value-1; a single-entry space still gets one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cmp_unit.sv
// cmp_unit: combinational unsigned magnitude comparator.
//   a, b : DATA_W-bit unsigned operands
//   g    : a >  b
//   e    : a == b
//   l    : a <  b
// Exactly one of g/e/l is high for any pair of known operands.
module cmp_unit #(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              g,
  output logic              e,
  output logic              l
);

  always_comb begin
    g = (a > b);
    e = (a == b);
    l = (a < b);
  end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads N unsigned words, bubble-sorts them in place with one
// shared comparator (one compare per cycle), then streams them out ascending.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : load handshake, in_data is the word (LOAD only)
//   out_valid/out_ready : drain handshake, out_data is the sorted word
//   out_last            : marks the final word of the batch
//   busy                : high while sorting or draining
// Build option CMP_SORT_EARLY_EXIT_EN: stop sorting after the first pass that
// performs no swap. Without it all N-1 passes always run (N(N-1)/2 cycles).
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int unsigned N      = DefaultN,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned     IdxW     = clog2(N);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N - 1);
  localparam logic [IdxW-1:0] LastPass = IdxW'(N - 2);

  state_e            state_q;
  logic [IdxW-1:0]   wr_idx_q;
  logic [IdxW-1:0]   rd_idx_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   pass_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;
  logic [DATA_W-1:0] out_data_q;

  // Batch storage; contents are meaningless until a full batch is loaded.
  logic [DATA_W-1:0] mem_q [N];

`ifdef CMP_SORT_EARLY_EXIT_EN
  logic swapped_q;
`endif

  logic [IdxW-1:0]   idx_plus1;
  logic [IdxW-1:0]   rd_plus1;
  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;
  logic              cmp_g;
  logic              cmp_e;
  logic              cmp_l;
  logic              load_fire;
  logic              out_fire;
  logic              swap_en;
  logic              pass_end;
  logic              last_pass;
  logic              sort_done;
  logic [DATA_W-1:0] head_nxt;

  cmp_unit #(
    .DATA_W (DATA_W)
  ) u_cmp_unit (
    .a (cmp_a),
    .b (cmp_b),
    .g (cmp_g),
    .e (cmp_e),
    .l (cmp_l)
  );

  always_comb begin
    idx_plus1 = idx_q + 1'b1;
    rd_plus1  = rd_idx_q + 1'b1;
    cmp_a     = mem_q[idx_q];
    cmp_b     = mem_q[idx_plus1];
    load_fire = in_valid && in_ready_q;
    out_fire  = out_valid_q && out_ready;
    // Only a strict greater-than swaps, so equal words keep load order.
    swap_en   = (state_q == StSort) && cmp_g && !(cmp_e || cmp_l);
    pass_end  = (idx_q == (LastPass - pass_q));
    last_pass = (pass_q == LastPass);
`ifdef CMP_SORT_EARLY_EXIT_EN
    sort_done = pass_end && (last_pass || !(swapped_q || swap_en));
`else
    sort_done = pass_end && last_pass;
`endif
    // Word 0 as it will be after this edge, so DRAIN can present it at once.
    head_nxt  = (swap_en && (idx_q == '0)) ? cmp_b : mem_q[0];
  end

  // Storage has no reset: a new batch always overwrites every entry first.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_q[wr_idx_q] <= in_data;
    end else if (swap_en) begin
      mem_q[idx_q]     <= cmp_b;
      mem_q[idx_plus1] <= cmp_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
      swapped_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StLoad: begin
          if (load_fire) begin
            if (wr_idx_q == LastIdx) begin
              state_q    <= StSort;
              wr_idx_q   <= '0;
              idx_q      <= '0;
              pass_q     <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
`ifdef CMP_SORT_EARLY_EXIT_EN
              swapped_q  <= 1'b0;
`endif
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
            end
          end
        end

        StSort: begin
          if (sort_done) begin
            state_q     <= StDrain;
            idx_q       <= '0;
            pass_q      <= '0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            out_data_q  <= head_nxt;
          end else if (pass_end) begin
            idx_q  <= '0;
            pass_q <= pass_q + 1'b1;
          end else begin
            idx_q <= idx_plus1;
          end
`ifdef CMP_SORT_EARLY_EXIT_EN
          if (pass_end) begin
            swapped_q <= 1'b0;
          end else if (swap_en) begin
            swapped_q <= 1'b1;
          end
`endif
        end

        StDrain: begin
          if (out_fire) begin
            if (rd_idx_q == LastIdx) begin
              state_q     <= StLoad;
              rd_idx_q    <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              rd_idx_q   <= rd_plus1;
              out_data_q <= mem_q[rd_plus1];
              out_last_q <= (rd_plus1 == LastIdx);
            end
          end
        end

        default: begin
          state_q     <= StLoad;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_last  = out_last_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Self-checking bench for cmp_sort_ctrl (N=8, DATA_W=4): a transaction-level
// model predicts every output each cycle; directed batches add literal checks.
module tb_cmp_sort_ctrl;

  localparam int N = 8;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int errors = 0;
  int checks = 0;

  cmp_sort_ctrl #(
    .N      (N),
    .DATA_W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sort duration from the data alone. Each bubble pass moves every element
  // with a larger predecessor one slot left, so the swapping passes equal the
  // largest count of larger predecessors; early exit adds one clean pass.
  function automatic int sort_cycles(input logic [W-1:0] w[$]);
`ifdef CMP_SORT_EARLY_EXIT_EN
    int maxinv = 0;
    int passes;
    int cyc = 0;
    for (int i = 0; i < N; i++) begin
      int c = 0;
      for (int j = 0; j < i; j++) if (w[j] > w[i]) c++;
      if (c > maxinv) maxinv = c;
    end
    passes = (maxinv + 1 > N - 1) ? N - 1 : maxinv + 1;
    for (int p = 0; p < passes; p++) cyc += N - 1 - p;
    return cyc;
`else
    if (w.size() != N) return 0;
    return N * (N - 1) / 2;
`endif
  endfunction

  // Model: 0 = loading, 1 = sorting, 2 = draining.
  int           m_phase = 0;
  int           m_sc = 0;
  int           m_len = 0;
  int           m_rd = 0;
  logic [W-1:0] m_words[$];
  logic [W-1:0] m_sorted[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_sc    = 0;
      m_rd    = 0;
      m_words.delete();
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_words.push_back(in_data);
          if (m_words.size() == N) begin
            m_sorted = m_words;
            m_sorted.sort();
            m_len = sort_cycles(m_words);
            m_words.delete();
            m_sc    = 0;
            m_phase = 1;
          end
        end
        1: begin
          m_sc++;
          if (m_sc == m_len) begin
            m_phase = 2;
            m_rd    = 0;
          end
        end
        default: if (out_ready) begin
          m_rd++;
          if (m_rd == N) m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_phase == 0);
    check("busy", busy, m_phase != 0);
    check("out_valid", out_valid, m_phase == 2);
    check("out_last", out_last, (m_phase == 2) && (m_rd == N - 1));
    if (!rst_n) check("rst_out_data", out_data, 0);
    else if (m_phase == 2) check("out_data", out_data, m_sorted[m_rd]);
  end

  task automatic send_batch(input logic [W-1:0] w[$], input bit gaps);
    foreach (w[i]) begin
      int t = 0;
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = w[i];
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        check("load_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: 1-0-0-1 toggle, 2: random.
  task automatic drain_batch(input int mode, input bit junk,
                             output logic [W-1:0] got[$], output int sort_cyc);
    int           k = 0;
    bit           stalled = 1'b0;
    logic [W-1:0] held = '0;
    got.delete();
    sort_cyc = 0;
    in_valid = junk;
    in_data  = 4'h5;
    while (got.size() < N && k < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (busy && !out_valid) sort_cyc++;
      if (stalled && out_valid) check("stall_stable", out_data, held);
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (got.size() == N) begin
          check("last_on_final", out_last, 1);
          in_valid = 1'b0;
        end
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (k >= 400) check("drain_timeout", 1, 0);
  endtask

  task automatic check_list(input string name, input logic [W-1:0] got[$],
                            input logic [W-1:0] exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      if (got[i] !== exp[i]) begin
        check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        return;
      end
    end
    checks++;
  endtask

  initial begin
    logic [W-1:0] w[$];
    logic [W-1:0] got[$];
    logic [W-1:0] exp[$];
    int           sc;
    int           short_sort;

`ifdef CMP_SORT_EARLY_EXIT_EN
    short_sort = 7;
`else
    short_sort = 28;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_data", out_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reversed batch: full-length sort.
    w = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    send_batch(w, 1'b0);
    drain_batch(0, 1'b0, got, sc);
    check("rev_sort_cycles", sc, 28);
    exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    check_list("rev_out", got, exp);

    // Already sorted.
    w = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    send_batch(w, 1'b0);
    drain_batch(0, 1'b0, got, sc);
    check("sorted_sort_cycles", sc, short_sort);
    check_list("sorted_out", got, exp);

    // All equal.
    w = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
    send_batch(w, 1'b0);
    drain_batch(0, 1'b0, got, sc);
    check("equal_sort_cycles", sc, short_sort);
    check_list("equal_out", got, w);

    // Mixed data with a stalling consumer.
    w = '{4'h3, 4'hF, 4'h0, 4'h9, 4'h9, 4'h1, 4'hC, 4'h2};
    send_batch(w, 1'b0);
    drain_batch(1, 1'b0, got, sc);
    exp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h9, 4'h9, 4'hC, 4'hF};
    check_list("stall_out", got, exp);

    // Reset mid-sort, then a fresh batch.
    w = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    send_batch(w, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    w = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    send_batch(w, 1'b0);
    drain_batch(0, 1'b0, got, sc);
    exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    check_list("after_rst_out", got, exp);

    // Junk in_valid while busy must not disturb the batch.
    w = '{4'h2, 4'hB, 4'h7, 4'h0, 4'hE, 4'h7, 4'h4, 4'h9};
    send_batch(w, 1'b0);
    drain_batch(2, 1'b1, got, sc);
    exp = '{4'h0, 4'h2, 4'h4, 4'h7, 4'h7, 4'h9, 4'hB, 4'hE};
    check_list("junk_out", got, exp);

    // Random batches, random gaps, random back-pressure.
    for (int b = 0; b < 8; b++) begin
      w.delete();
      for (int i = 0; i < N; i++) w.push_back(W'($urandom));
      send_batch(w, 1'b1);
      drain_batch(2, 1'($urandom_range(0, 1)), got, sc);
      exp = w;
      exp.sort();
      check_list("rand_out", got, exp);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_sort_ctrl.md
CMP_SORT_CTRL -- requirements
Module: cmp_sort_ctrl

Interface
REQ-001 Parameter N, default 8, number of words per sort batch; legal range 2..16.
REQ-002 Parameter DATA_W, default 4, width of each unsigned word.
REQ-003 Port clk, input, 1 bit: single clock, rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: in_data holds a valid word.
REQ-006 Port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-007 Port in_data, input, DATA_W bits: unsigned word to load.
REQ-008 Port out_valid, output, 1 bit: out_data holds a valid sorted word.
REQ-009 Port out_ready, input, 1 bit: consumer accepts a word this cycle.
REQ-010 Port out_data, output, DATA_W bits: sorted word, ascending order.
REQ-011 Port out_last, output, 1 bit: out_data is the final word of the batch.
REQ-012 Port busy, output, 1 bit: block is in SORT or DRAIN.

Function
REQ-013 The block SHALL implement an FSM with states LOAD, SORT and DRAIN.
REQ-014 In LOAD, the block SHALL drive in_ready=1 and SHALL hold in_ready=0 in every other state.
REQ-015 On each in_valid && in_ready, the block SHALL store in_data at buf[wr_idx] and increment wr_idx.
REQ-016 After the N-th accepted word, the block SHALL enter SORT on the next edge with wr_idx=0, pass=0, idx=0.
REQ-017 In SORT, the block SHALL perform exactly one comparison per cycle, comparing buf[idx] with buf[idx+1] through the shared comparator.
REQ-018 If the comparator g output is 1, the block SHALL swap the two words on that edge; if e=1 or l=1, it SHALL leave them in place, so equal words keep their load order.
REQ-019 The block SHALL increment idx each SORT cycle; when idx == N-2-pass, it SHALL reset idx to 0 and increment pass.
REQ-020 When pass reaches N-1, the block SHALL enter DRAIN; SORT SHALL take exactly N(N-1)/2 cycles (28 cycles for N=8).
REQ-021 In DRAIN, the block SHALL assert out_valid=1 and drive out_data=buf[rd_idx], with out_last=1 when rd_idx==N-1.
REQ-022 On out_valid && out_ready, the block SHALL increment rd_idx; out_data SHALL remain stable while out_ready=0.
REQ-023 After the last word transfers, the block SHALL return to LOAD on the next edge with rd_idx=0.
REQ-024 in_valid SHALL be ignored outside LOAD, and out_ready SHALL be ignored outside DRAIN.

Reset
REQ-025 When rst_n=0, the block SHALL force state=LOAD, all indices and pass=0, in_ready=1 after reset, and out_valid=0, out_last=0, busy=0, out_data=0.
REQ-026 Buffer contents SHALL be don't-care after reset; a reset during SORT or DRAIN SHALL abandon the batch with no partial output.

Configuration
REQ-027 With CMP_SORT_EARLY_EXIT_EN defined, the block SHALL track a per-pass swap flag and enter DRAIN at the end of any pass with no swap, so an already-sorted batch takes N-1 SORT cycles.
REQ-028 Without CMP_SORT_EARLY_EXIT_EN, the block SHALL always run all N-1 passes (REQ-020), and no swap flag SHALL be instantiated.

Structure
REQ-029 Package cmp_sort_pkg SHALL hold the state enum type, the default DATA_W and N constants, and an index-width function clog2(N).
REQ-030 The block SHALL instantiate one sub-module, cmp_unit: a combinational DATA_W-bit unsigned magnitude comparator with outputs g/e/l, exactly one of which is high.

Verification
REQ-031 Load 7,6,5,4,3,2,1,0 -> after 28 busy SORT cycles, the output is 0..7 with out_last on the 8th word.
REQ-032 Load 0..7 already sorted -> output 0..7; with CMP_SORT_EARLY_EXIT_EN, SORT lasts 7 cycles, otherwise 28.
REQ-033 Load eight words of value 4'hA -> no swaps occur and the output is eight 4'hA words.
REQ-034 Load 3,F,0,9,9,1,C,2 with out_ready toggling 1-0-0-1 -> output 0,1,2,3,9,9,C,F with out_data stable during stalls.
REQ-035 Assert rst_n=0 at SORT cycle 10, then load 1..8 reversed -> output 1..8 with no residue from the first batch.
REQ-036 Drive in_valid=1 during SORT/DRAIN with data 4'h5 -> in_ready stays 0 and the batch output is unaffected.
